// File: rtl/sar_pkg.sv
// sar_pkg: shared types and channel-search helper for the SAR conversion sequencer.
package sar_pkg;
  typedef enum logic [2:0] {IDLE, SEL, SAMPLE, SETTLE, CONV, GAP} state_t;
  localparam int NCH     = 4;
  localparam int NCH_MAX = 16;
  localparam int CH_W    = $clog2(NCH);
  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;
  // Lowest set bit of mask at an index >= ptr; descending scan so the lowest hit wins.
  function automatic pick_t find_next(input logic [NCH_MAX-1:0] mask, input logic [4:0] ptr);
    pick_t p;
    p = '0;
    for (int i = NCH_MAX - 1; i >= 0; i--)
      if (mask[i] && 5'(i) >= ptr) p = '{found: 1'b1, idx: 4'(i)};
    return p;
  endfunction
endpackage

// File: rtl/sar_ch_pick.sv
// sar_ch_pick: combinational priority search for the next scanned channel at or above ch_ptr.
module sar_ch_pick
  import sar_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] mask,
  input  logic [CW:0]    ptr,
  output logic           found,
  output logic [CW-1:0]  idx
);
  pick_t p;
  always_comb begin
    p = find_next(NCH_MAX'(mask), 5'(ptr));
    found = p.found;
    idx = CW'(p.idx);
  end
endmodule

// File: rtl/sar_conv_ctrl.sv
// sar_conv_ctrl: scans masked channels through sample/settle/convert and captures SAR results
// with a valid/ready handshake, sticky timeout and overrun flags.
module sar_conv_ctrl
  import sar_pkg::*;
#(
  parameter int NBITS       = 8,
  parameter int NCH         = 4,
  parameter int SAMPLE_CYC  = 4,
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 32,
  parameter bit DOUT_INV    = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     trig,
  input  logic                     cont,
  input  logic [NCH-1:0]           ch_mask,
  input  logic                     clr_err,
  output logic                     sar_en,
  output logic                     sar_start,
  output logic                     sample,
  output logic [$clog2(NCH)-1:0]   ch_sel,
  input  logic                     sar_eoc,
  input  logic [NBITS-1:0]         sar_dout,
  output logic [NBITS-1:0]         res_data,
  output logic [$clog2(NCH)-1:0]   res_ch,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     busy,
  output logic                     err_timeout,
  output logic                     overrun
);
  localparam int CW    = $clog2(NCH);
  localparam int PW    = CW + 1;
  localparam int CMAX  = (SAMPLE_CYC > SETTLE_CYC) ? ((SAMPLE_CYC > TIMEOUT_CYC) ? SAMPLE_CYC : TIMEOUT_CYC)
                                                   : ((SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC);
  localparam int CNT_W = $clog2(CMAX + 1);
  state_t           state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [NCH-1:0]   scan_mask;
  logic [PW-1:0]    ch_ptr;
  logic             found, eoc_hit, tmo, relatch;
  logic [CW-1:0]    pick;
  sar_ch_pick #(.NCH(NCH)) u_pick (
    .mask  (scan_mask),
    .ptr   (ch_ptr),
    .found (found),
    .idx   (pick)
  );
  assign sar_en    = state inside {SAMPLE, SETTLE, CONV};
  assign sar_start = state == CONV;
  assign sample    = state == SAMPLE;
  assign busy      = state != IDLE;
  // A continuous-mode restart re-latches the mask and spends one more SEL cycle on the search.
  always_comb begin
    eoc_hit = en && state == CONV && sar_eoc;
    tmo = en && state == CONV && !sar_eoc && cnt == CNT_W'(TIMEOUT_CYC - 1);
    relatch = en && |ch_mask && ((state == IDLE && trig) || (state == SEL && !found && cont));
    nxt = state;
    if (!en) nxt = IDLE;
    else
      case (state)
        IDLE:    nxt = relatch ? SEL : IDLE;
        SEL:     nxt = found ? SAMPLE : (relatch ? SEL : IDLE);
        SAMPLE:  nxt = cnt == CNT_W'(SAMPLE_CYC - 1) ? SETTLE : SAMPLE;
        SETTLE:  nxt = cnt == CNT_W'(SETTLE_CYC - 1) ? CONV : SETTLE;
        CONV:    nxt = (eoc_hit || tmo) ? GAP : CONV;
        GAP:     nxt = SEL;
        default: nxt = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      scan_mask <= '0;
      ch_ptr <= '0;
      ch_sel <= '0;
      res_data <= '0;
      res_ch <= '0;
      res_valid <= 1'b0;
      err_timeout <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (nxt != state) ? '0 : cnt + 1'b1;
      if (relatch) begin
        scan_mask <= ch_mask;
        ch_ptr <= '0;
      end else if (en && state == GAP) ch_ptr <= PW'(ch_sel) + 1'b1;
      if (en && state == SEL && found) ch_sel <= pick;
      if (eoc_hit) begin
        res_data <= sar_dout ^ {NBITS{DOUT_INV}};
        res_ch <= ch_sel;
      end
      res_valid <= eoc_hit | (res_valid & ~res_ready);
      overrun <= (eoc_hit & res_valid & ~res_ready) | (overrun & ~clr_err);
      err_timeout <= tmo | (err_timeout & ~clr_err);
    end
endmodule

// File: tb/tb_sar_conv_ctrl.sv
// tb_sar_conv_ctrl: table-driven, directed and randomized checks of sar_conv_ctrl against a scan-level model.
module tb_sar_conv_ctrl;
  logic       clk = 0, rst_n = 0, en = 0, trig = 0, cont = 0, clr_err = 0, sar_eoc = 0, res_ready = 1;
  logic [3:0] ch_mask = '0;
  logic [7:0] sar_dout = '0;
  logic       sar_en, sar_start, sample, res_valid, busy, err_timeout, overrun;
  logic [1:0] ch_sel, res_ch;
  logic [7:0] res_data;
  logic       i_sar_en, i_sar_start, i_sample, i_res_valid, i_busy, i_err_timeout, i_overrun;
  logic [1:0] i_ch_sel, i_res_ch;
  logic [7:0] i_res_data;

  sar_conv_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .trig(trig), .cont(cont), .ch_mask(ch_mask), .clr_err(clr_err),
    .sar_en(sar_en), .sar_start(sar_start), .sample(sample), .ch_sel(ch_sel), .sar_eoc(sar_eoc),
    .sar_dout(sar_dout), .res_data(res_data), .res_ch(res_ch), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy), .err_timeout(err_timeout), .overrun(overrun));

  sar_conv_ctrl #(.DOUT_INV(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .en(en), .trig(trig), .cont(cont), .ch_mask(ch_mask), .clr_err(clr_err),
    .sar_en(i_sar_en), .sar_start(i_sar_start), .sample(i_sample), .ch_sel(i_ch_sel), .sar_eoc(sar_eoc),
    .sar_dout(sar_dout), .res_data(i_res_data), .res_ch(i_res_ch), .res_valid(i_res_valid),
    .res_ready(res_ready), .busy(i_busy), .err_timeout(i_err_timeout), .overrun(i_overrun));

  always #5 clk = ~clk;

  typedef struct {logic [1:0] ch; logic [7:0] d;} res_t;
  typedef struct {logic [3:0] m; int n; int cnt; int cyc; bit to;} vec_t;
  res_t       got[$], exp_q[$];
  int         checks = 0, errors = 0;
  int         eoc_n[4];
  logic [7:0] dout_tab[4];
  int         ccnt = 0, sw = 0;
  bit         mon_en = 1;

  task automatic check(input string nm, input int got_v, input int exp_v);
    checks++;
    if (got_v != exp_v) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got_v, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // SAR logic stand-in: raises eoc on the Nth clock of sar_start for the selected channel.
  always @(negedge clk) begin
    ccnt = sar_start ? ccnt + 1 : 0;
    sar_eoc = sar_start && ccnt == eoc_n[ch_sel];
    sar_dout = dout_tab[ch_sel];
  end

  always @(negedge clk) if (res_valid && res_ready) got.push_back('{res_ch, res_data});

  always @(negedge clk)
    if (mon_en) begin
      if (sample) sw++;
      else if (sw != 0) begin
        check("sample_width", sw, 4);
        sw = 0;
      end
    end

  task automatic model_scan(input logic [3:0] m, output int cyc, output bit to);
    exp_q.delete();
    cyc = 1;
    to = 0;
    for (int c = 0; c < 4; c++)
      if (m[c]) begin
        if (eoc_n[c] <= 32) exp_q.push_back('{2'(c), dout_tab[c]});
        else to = 1;
        cyc += 8 + ((eoc_n[c] <= 32) ? eoc_n[c] : 32);
      end
  endtask

  task automatic run_scan(input logic [3:0] m, input bit scramble, output int cyc, output bit to);
    got.delete();
    tick();
    ch_mask = m;
    trig = 1;
    clr_err = 1;
    tick();
    trig = 0;
    clr_err = 0;
    if (scramble) ch_mask = 4'($urandom);
    cyc = 0;
    while (busy && cyc < 3000) begin
      cyc++;
      tick();
    end
    to = err_timeout;
  endtask

  task automatic cmp_results(input string nm);
    check({nm, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      check({nm, "_ch"}, int'(got[i].ch), int'(exp_q[i].ch));
      check({nm, "_data"}, int'(got[i].d), int'(exp_q[i].d));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t vt[5];
    int   cyc, mcyc, k;
    bit   to, mto;
    vt[0] = '{4'b0101, 9, 2, 35, 0};
    vt[1] = '{4'b1000, 1, 1, 10, 0};
    vt[2] = '{4'b0010, 40, 0, 41, 1};
    vt[3] = '{4'b1111, 3, 4, 45, 0};
    vt[4] = '{4'b0110, 32, 2, 81, 0};
    for (int c = 0; c < 4; c++) begin
      eoc_n[c] = 9;
      dout_tab[c] = 8'h00;
    end
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_sar_en", sar_en, 0);
    check("rst_sample", sample, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_err", err_timeout, 0);
    check("rst_overrun", overrun, 0);
    check("rst_res_data", res_data, 0);
    rst_n = 1;
    en = 1;
    tick();

    dout_tab[0] = 8'hA5;
    dout_tab[2] = 8'h3C;
    run_scan(4'b0101, 0, cyc, to);
    check("basic_cycles", cyc, 35);
    check("basic_count", got.size(), 2);
    if (got.size() == 2) begin
      check("basic_ch0", got[0].ch, 0);
      check("basic_d0", got[0].d, 8'hA5);
      check("basic_ch1", got[1].ch, 2);
      check("basic_d1", got[1].d, 8'h3C);
    end
    check("basic_inv_data", i_res_data, 8'hC3);

    dout_tab[0] = 8'h0F;
    run_scan(4'b0001, 0, cyc, to);
    check("inv_plain", res_data, 8'h0F);
    check("inv_data", i_res_data, 8'hF0);

    for (int v = 0; v < 5; v++) begin
      for (int c = 0; c < 4; c++) begin
        eoc_n[c] = vt[v].n;
        dout_tab[c] = 8'($urandom);
      end
      model_scan(vt[v].m, mcyc, mto);
      run_scan(vt[v].m, 0, cyc, to);
      check("tab_cycles", cyc, vt[v].cyc);
      check("tab_count", got.size(), vt[v].cnt);
      check("tab_timeout", to, vt[v].to);
      cmp_results("tab");
    end

    eoc_n[1] = 99;
    run_scan(4'b0010, 0, cyc, to);
    check("tmo_flag", to, 1);
    check("tmo_count", got.size(), 0);
    check("tmo_valid", res_valid, 0);
    check("tmo_busy", busy, 0);
    clr_err = 1;
    tick();
    clr_err = 0;
    check("tmo_clear", err_timeout, 0);

    res_ready = 0;
    eoc_n[0] = 5;
    eoc_n[1] = 5;
    dout_tab[0] = 8'h11;
    dout_tab[1] = 8'h22;
    run_scan(4'b0011, 0, cyc, to);
    check("ovr_flag", overrun, 1);
    check("ovr_data", res_data, 8'h22);
    check("ovr_ch", res_ch, 1);
    check("ovr_valid", res_valid, 1);

    ch_mask = 4'b0001;
    trig = 1;
    tick();
    trig = 0;
    k = 0;
    while (!sample && k < 50) begin
      k++;
      tick();
    end
    check("rstmid_in_sample", sample, 1);
    mon_en = 0;
    rst_n = 0;
    #1;
    check("rstmid_sample", sample, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_sar_en", sar_en, 0);
    check("rstmid_valid", res_valid, 0);
    check("rstmid_overrun", overrun, 0);
    check("rstmid_data", res_data, 0);
    check("rstmid_ch", res_ch, 0);
    tick();
    rst_n = 1;
    sw = 0;
    mon_en = 1;
    res_ready = 1;

    ch_mask = 4'b0000;
    trig = 1;
    tick();
    trig = 0;
    for (int i = 0; i < 3; i++) begin
      check("zero_mask_busy", busy, 0);
      tick();
    end

    cont = 1;
    eoc_n[3] = 4;
    dout_tab[3] = 8'h5A;
    got.delete();
    ch_mask = 4'b1000;
    trig = 1;
    tick();
    trig = 0;
    k = 0;
    while (got.size() < 3 && k < 500) begin
      k++;
      tick();
    end
    check("cont_count", int'(got.size() >= 3), 1);
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      check("cont_ch", got[i].ch, 3);
      check("cont_data", got[i].d, 8'h5A);
    end
    eoc_n[3] = 20;
    k = 0;
    while (!sar_start && k < 100) begin
      k++;
      tick();
    end
    check("abort_in_conv", sar_start, 1);
    en = 0;
    tick();
    check("abort_busy", busy, 0);
    check("abort_sar_en", sar_en, 0);
    check("abort_start", sar_start, 0);
    check("abort_sample", sample, 0);
    cont = 0;
    en = 1;
    tick();

    for (int it = 0; it < 20; it++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      for (int c = 0; c < 4; c++) begin
        eoc_n[c] = $urandom_range(1, 36);
        dout_tab[c] = 8'($urandom);
      end
      model_scan(m, mcyc, mto);
      run_scan(m, 1, cyc, to);
      check("rnd_cycles", cyc, mcyc);
      check("rnd_timeout", to, mto);
      cmp_results("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
